// File: rtl/dispersion_injector_pkg.sv
// Shared types and helpers for the dispersion injector.
//   state_e : sweep controller states (IDLE, ARM, INJECT)
//   ch_w()  : channel-index width for a given channel count
//   sat_add : unsigned add that clamps to all ones of a chosen width
package dispersion_injector_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    INJECT = 2'd2
  } state_e;

  // Width of the channel index; a single-channel build still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SAT_W = 64;

  // Operands are zero-extended to SAT_W by the caller. The result is clamped
  // to w bits of ones when the true sum does not fit in w bits (w < SAT_W).
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int               w);
    logic [SAT_W:0]   sum;
    logic [SAT_W-1:0] ones;
    sum  = {1'b0, a} + {1'b0, b};
    ones = {SAT_W{1'b1}} >> (SAT_W - w);
    if (sum > {1'b0, ones}) return ones;
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/bram_infer.sv
// Simple dual-port RAM with a registered read port, written so that it maps
// onto block RAM. Contents are not reset.
//   clk     : clock
//   wen_i   : write enable for waddr_i/wdata_i
//   ren_i   : read enable; rdata_o holds while low
//   raddr_i : read address, data appears on rdata_o one cycle later
//   rdata_o : registered read data
module bram_infer #(
  parameter int N_ADDR     = 2048,
  parameter int DATA_WIDTH = 10,
  localparam int AW        = (N_ADDR > 1) ? $clog2(N_ADDR) : 1
) (
  input  logic                  clk,
  input  logic                  wen_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  ren_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [N_ADDR];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (wen_i) mem[waddr_i] <= wdata_i;
    if (ren_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dispersion_injector.sv
// Dispersion injector: passes a channel-ordered power stream through with a
// fixed 2-cycle latency and, once armed, adds an amplitude to channel c of the
// spectrum whose index (counted from the first channel-0 sample after arming)
// equals delay[c], producing a synthetic dispersed sweep.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ce                  : clock enable, all state holds while low
//   din, din_valid, sync: input stream; sync marks channel 0
//   inject_start/amp    : arm request and amplitude latched with it
//   dly_we/addr/wdata   : delay table write port (honoured only when idle)
//   dout, dout_valid    : output stream
//   busy                : sweep armed or in progress
//   done                : pulse with the final swept output sample
module dispersion_injector
  import dispersion_injector_pkg::*;
#(
  parameter int N_CHANNELS  = 2048,
  parameter int DIN_WIDTH   = 32,
  parameter int DELAY_WIDTH = 10,
  parameter int AMP_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ce,
  input  logic [DIN_WIDTH-1:0]            din,
  input  logic                            din_valid,
  input  logic                            sync,
  input  logic                            inject_start,
  input  logic [AMP_WIDTH-1:0]            inject_amp,
  input  logic                            dly_we,
  input  logic [ch_w(N_CHANNELS)-1:0]     dly_addr,
  input  logic [DELAY_WIDTH-1:0]          dly_wdata,
  output logic [DIN_WIDTH-1:0]            dout,
  output logic                            dout_valid,
  output logic                            busy,
  output logic                            done
);

  localparam int CH_W = ch_w(N_CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CHANNELS - 1);

  // Controller state
  state_e                 state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [DELAY_WIDTH-1:0] spec_q, spec_d;
  logic [DELAY_WIDTH-1:0] max_dly_q, max_dly_d;
  logic [AMP_WIDTH-1:0]   amp_q, amp_d;

  // Per-sample view of the incoming sample
  logic [CH_W-1:0]        ch_cur;
  logic [DELAY_WIDTH-1:0] spec_cur;
  logic                   in_sweep;
  logic                   is_last;
  logic                   tbl_wen;

  // Pipeline
  logic                   s1_valid_q, s1_inj_q, s1_last_q;
  logic [DIN_WIDTH-1:0]   s1_din_q;
  logic [DELAY_WIDTH-1:0] s1_spec_q;
  logic [DELAY_WIDTH-1:0] rd_dly;
  logic [SAT_W-1:0]       sum_full;
  logic [DIN_WIDTH-1:0]   sum_sat;
  logic                   hit;
  logic [DIN_WIDTH-1:0]   dout_q;
  logic                   dout_valid_q, done_q;

  always_comb begin
    ch_cur   = (din_valid && sync) ? '0 : ch_q;
    // The channel-0 sample that ends ARM already belongs to spectrum 0.
    in_sweep = (state_q == INJECT) || ((state_q == ARM) && (ch_cur == '0));
    spec_cur = (state_q == INJECT) ? spec_q : '0;
    is_last  = in_sweep && (ch_cur == LAST_CH) && (spec_cur == max_dly_q);
    tbl_wen  = ce && dly_we && (state_q == IDLE);
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    spec_d    = spec_q;
    max_dly_d = max_dly_q;
    amp_d     = amp_q;

    // The sweep length only grows; shrinking entries never cut it short.
    if (tbl_wen && (dly_wdata > max_dly_q)) max_dly_d = dly_wdata;
    if (din_valid) ch_d = ch_cur + 1'b1;

    case (state_q)
      IDLE: begin
        if (inject_start) begin
          state_d = ARM;
          amp_d   = inject_amp;
        end
      end
      ARM, INJECT: begin
        if (din_valid && in_sweep) begin
          state_d = INJECT;
          spec_d  = spec_cur;
          if (ch_cur == LAST_CH) begin
            if (spec_cur == max_dly_q) begin
              state_d = IDLE;
              spec_d  = '0;
            end else begin
              spec_d = spec_cur + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      spec_q    <= '0;
      max_dly_q <= '0;
      amp_q     <= '0;
    end else if (ce) begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      spec_q    <= spec_d;
      max_dly_q <= max_dly_d;
      amp_q     <= amp_d;
    end
  end

  // Delay table: read address is the incoming sample's channel, so the
  // delay lines up with that sample in S1.
  bram_infer #(
    .N_ADDR     (N_CHANNELS),
    .DATA_WIDTH (DELAY_WIDTH)
  ) u_dly_tbl (
    .clk     (clk),
    .wen_i   (tbl_wen),
    .waddr_i (dly_addr),
    .wdata_i (dly_wdata),
    .ren_i   (ce),
    .raddr_i (ch_cur),
    .rdata_o (rd_dly)
  );

  // S2 datapath. amp_q is stable for the whole sweep; it can only be
  // reloaded after the last sample has left S2.
  always_comb begin
    hit      = s1_inj_q && (s1_spec_q == rd_dly);
    sum_full = sat_add(SAT_W'(s1_din_q), SAT_W'(amp_q), DIN_WIDTH);
    sum_sat  = sum_full[DIN_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_inj_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_din_q     <= '0;
      s1_spec_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else if (ce) begin
      s1_valid_q   <= din_valid;
      s1_inj_q     <= din_valid && in_sweep;
      s1_last_q    <= din_valid && is_last;
      s1_din_q     <= din;
      s1_spec_q    <= spec_cur;
      dout_q       <= hit ? sum_sat : s1_din_q;
      dout_valid_q <= s1_valid_q;
      done_q       <= s1_valid_q && s1_last_q;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dispersion_injector.sv
module tb_dispersion_injector;

  localparam int N  = 8;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst_n, ce, din_valid, sync, inject_start, dly_we;
  logic [15:0] din, inject_amp;
  logic [2:0]  dly_addr;
  logic [3:0]  dly_wdata;
  logic [15:0] dout;
  logic        dout_valid, busy, done;

  always #5 clk = ~clk;

  dispersion_injector #(
    .N_CHANNELS(N), .DIN_WIDTH(16), .DELAY_WIDTH(DW), .AMP_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .din_valid(din_valid),
    .sync(sync), .inject_start(inject_start), .inject_amp(inject_amp),
    .dly_we(dly_we), .dly_addr(dly_addr), .dly_wdata(dly_wdata),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { int d; bit last; } exp_t;
  exp_t exp_q[$];
  int   m_ch, m_mode, m_spec, m_amp, m_max;   // m_mode: 0 idle, 1 armed, 2 sweeping
  int   m_tbl [N];

  initial foreach (m_tbl[i]) m_tbl[i] = 0;

  always @(posedge clk or negedge rst_n) begin
    int old_mode, c, e;
    bit last;
    if (!rst_n) begin
      m_ch = 0; m_mode = 0; m_spec = 0; m_amp = 0; m_max = 0;
      exp_q.delete();
    end else if (ce) begin
      old_mode = m_mode;
      if (din_valid) begin
        c    = sync ? 0 : m_ch;
        m_ch = (c + 1) % N;
        e    = int'(din);
        last = 0;
        if (m_mode == 1 && c == 0) begin m_mode = 2; m_spec = 0; end
        if (m_mode == 2) begin
          if (m_tbl[c] == m_spec) e = (e + m_amp > 65535) ? 65535 : e + m_amp;
          if (c == N - 1) begin
            if (m_spec == m_max) begin last = 1; m_mode = 0; end
            else m_spec++;
          end
        end
        exp_q.push_back('{e, last});
      end
      if (old_mode == 0 && dly_we) begin
        m_tbl[dly_addr] = int'(dly_wdata);
        if (int'(dly_wdata) > m_max) m_max = int'(dly_wdata);
      end
      if (old_mode == 0 && inject_start) begin m_mode = 1; m_amp = int'(inject_amp); end
    end
  end

  // ---------------- compare process ----------------
  logic ce_q = 1'b0;
  always @(posedge clk) ce_q <= ce;

  int out_log[$];
  bit done_log[$];
  int ref_log[$];
  bit ref_done[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, (m_mode != 0));
      if (ce_q) begin
        if (dout_valid) begin
          if (exp_q.size() == 0) chk("dout_without_expected_sample", exp_q.size(), 1);
          else begin
            exp_t x;
            x = exp_q.pop_front();
            chk("dout", dout, x.d);
            chk("done", done, x.last);
            out_log.push_back(int'(dout));
            done_log.push_back(done);
          end
        end else begin
          chk("done_without_valid", done, 0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr();
    ce = 1'b1; din_valid = 1'b0; sync = 1'b0; inject_start = 1'b0; dly_we = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk); clr();
    dly_we = 1'b1; dly_addr = 3'(a); dly_wdata = 4'(d);
  endtask

  task automatic start(input int amp);
    @(negedge clk); clr();
    inject_start = 1'b1; inject_amp = 16'(amp);
  endtask

  task automatic smp(input int d, input bit s);
    @(negedge clk); clr();
    din_valid = 1'b1; din = 16'(d); sync = s;
  endtask

  task automatic drain(input int n);
    repeat (n) begin @(negedge clk); clr(); end
  endtask

  task automatic clear_logs();
    out_log.delete(); done_log.delete();
  endtask

  task automatic compare_to_ref(string name, input int off);
    chk({name, "_count"}, out_log.size(), ref_log.size() + off);
    for (int i = 0; i < ref_log.size(); i++) begin
      if (i + off < out_log.size()) begin
        chk({name, "_sample"}, out_log[i + off], ref_log[i]);
        chk({name, "_done"}, done_log[i + off], ref_done[i]);
      end
    end
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; clr(); din = '0; inject_amp = '0; dly_addr = '0; dly_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_dout", dout, 0);
    chk("reset_dout_valid", dout_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;

    // Test 1: asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) smp(i + 1, 0);
    @(negedge clk); clr();
    #1 chk("t1_valid_before_reset", dout_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_async_dout", dout, 0);
    chk("t1_async_dout_valid", dout_valid, 0);
    chk("t1_async_busy", busy, 0);
    chk("t1_async_done", done, 0);
    @(negedge clk); rst_n = 1'b1;

    // Test 2: full sweep, delay[c] = c
    for (int c = 0; c < N; c++) wr(c, c);
    clear_logs();
    start(100);
    smp(10, 0);
    chk("t2_busy_after_start", busy, 1);
    for (int i = 1; i < 72; i++) smp(10, 0);
    drain(4);
    chk("t2_count", out_log.size(), 72);
    ndone = 0;
    foreach (done_log[i]) ndone += int'(done_log[i]);
    chk("t2_done_count", ndone, 1);
    if (out_log.size() == 72) begin
      for (int k = 0; k < N; k++) begin
        chk("t2_injected", out_log[k*8 + k], 110);
        chk("t2_neighbour", out_log[k*8 + (k + 1) % 8], 10);
      end
      chk("t2_done_position", done_log[63], 1);
      chk("t2_after_sweep", out_log[64], 10);
    end
    chk("t2_busy_end", busy, 0);
    ref_log  = out_log;
    ref_done = done_log;

    // Test 3: saturation, 2-cycle latency
    wr(0, 0);
    clear_logs();
    start(16'h0020);
    smp(16'hFFF0, 1);
    @(negedge clk); clr();
    chk("t3_latency_cycle1", dout_valid, 0);
    @(negedge clk); clr();
    chk("t3_latency_cycle2", dout_valid, 1);
    chk("t3_saturated", dout, 16'hFFFF);
    for (int i = 1; i < 64; i++) smp(16'hFFF0, 0);
    drain(4);
    if (out_log.size() >= 10) begin
      chk("t3_first", out_log[0], 16'hFFFF);
      chk("t3_pass", out_log[1], 16'hFFF0);
      chk("t3_spec1_ch1", out_log[9], 16'hFFFF);
    end else chk("t3_count", out_log.size(), 64);

    // Test 4: sparse valid plus ce=0 bursts with ignored requests
    clear_logs();
    start(100);
    for (int i = 0; i < 72; i++) begin
      smp(10, i == 0);
      repeat (2) begin @(negedge clk); clr(); end
      if (i % 10 == 5) begin
        repeat (3) begin
          @(negedge clk); clr();
          ce = 1'b0; din_valid = 1'b1; din = 16'd999;
          inject_start = 1'b1; inject_amp = 16'd7;
          dly_we = 1'b1; dly_addr = 3'd5; dly_wdata = 4'd0;
        end
      end
    end
    drain(4);
    compare_to_ref("t4", 0);

    // Test 5: sync at ch=3 while armed; start and table write while busy
    clear_logs();
    for (int i = 0; i < 3; i++) smp(10, 0);
    start(100);
    smp(10, 1);
    for (int i = 1; i < 11; i++) smp(10, 0);
    start(200);
    wr(3, 0);
    for (int i = 11; i < 72; i++) smp(10, 0);
    drain(4);
    compare_to_ref("t5", 3);

    // Test 6: reset during spectrum 4, then fresh sweep with retained table
    clear_logs();
    start(100);
    for (int i = 0; i < 35; i++) smp(10, 0);
    @(negedge clk); clr();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy_reset", busy, 0);
    chk("t6_valid_reset", dout_valid, 0);
    chk("t6_done_reset", done, 0);
    @(negedge clk); rst_n = 1'b1;
    wr(7, 7);   // reset cleared the sweep length; restore it
    clear_logs();
    start(100);
    for (int i = 0; i < 72; i++) smp(10, 0);
    drain(4);
    compare_to_ref("t6", 0);

    chk("final_no_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
